// File: rtl/dsdac_pkg.sv
// Shared widths and constants for the second-order delta-sigma DAC.
package dsdac_pkg;

   // Width of the first integrator: two guard bits above the sample width.
   function automatic int int1_w(input int bw);
      return bw + 2;
   endfunction

   // Width of the second integrator: four guard bits above the sample width.
   function automatic int int2_w(input int bw);
      return bw + 4;
   endfunction

   // Full-scale magnitude 2^(bw-1), used as the feedback level.
   function automatic int fs_const(input int bw);
      return 32'sd1 <<< (bw - 1);
   endfunction

endpackage

// File: rtl/delta_sigma_dac_sat_add.sv
// Three-operand signed adder whose result saturates to the W-bit signed range.
module sat_add #(
   parameter int W = 16
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] c,
   output logic signed [W-1:0] y
);

   // Two extra bits hold any sum of three W-bit operands without wrapping.
   localparam logic signed [W+1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [W+1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

   logic signed [W+1:0] sum;

   // Wide sum followed by clamping to the destination range.
   always_comb begin
      sum = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} + {{2{c[W-1]}}, c};
      if (sum > MAX_V) begin
         y = MAX_V[W-1:0];
      end else if (sum < MIN_V) begin
         y = MIN_V[W-1:0];
      end else begin
         y = sum[W-1:0];
      end
   end

endmodule

// File: rtl/delta_sigma_dac.sv
// Second-order delta-sigma modulator producing a 1-bit pulse-density stream.
module delta_sigma_dac
   import dsdac_pkg::*;
#(
   parameter int BW = 14
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [BW-1:0] dac_i,
   output logic          dac_o
);

   localparam int I1W = int1_w(BW);
   localparam int I2W = int2_w(BW);
   localparam logic signed [I1W-1:0] FS1 = I1W'(fs_const(BW));
   localparam logic signed [I2W-1:0] FS2 = I2W'(fs_const(BW));

   logic signed [BW-1:0]  x_q;
   logic signed [I1W-1:0] int1;
   logic signed [I2W-1:0] int2;

   logic signed [I1W-1:0] x_ext;
   logic signed [I1W-1:0] negfb1;
   logic signed [I1W-1:0] int1_n;
   logic signed [I2W-1:0] int1_ext;
   logic signed [I2W-1:0] negfb2;
   logic signed [I2W-1:0] int2_n;

   // Feedback mux: subtract +FS when the output is high, add FS when low.
   always_comb begin
      x_ext    = I1W'(x_q);
      int1_ext = I2W'(int1_n);
      if (dac_o) begin
         negfb1 = -FS1;
         negfb2 = -FS2;
      end else begin
         negfb1 = FS1;
         negfb2 = FS2;
      end
   end

   sat_add #(.W(I1W)) u_int1_add (
      .a (int1),
      .b (x_ext),
      .c (negfb1),
      .y (int1_n)
   );

   // The second stage consumes the freshly computed first-stage value.
   sat_add #(.W(I2W)) u_int2_add (
      .a (int2),
      .b (int1_ext),
      .c (negfb2),
      .y (int2_n)
   );

   // Loop state and output register; reset clears everything on the same edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q   <= '0;
         int1  <= '0;
         int2  <= '0;
         dac_o <= 1'b0;
      end else begin
         x_q   <= dac_i;
         int1  <= int1_n;
         int2  <= int2_n;
         dac_o <= ~int2_n[I2W-1];
      end
   end

endmodule

// File: tb/tb_delta_sigma_dac.sv
// Self-checking bench: integer reference model, per-cycle compare, density checks.
module tb_delta_sigma_dac;

   localparam int BW   = 14;
   localparam int FS   = 8192;
   localparam int I1MX = 32767;
   localparam int I1MN = -32768;
   localparam int I2MX = 131071;
   localparam int I2MN = -131072;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic signed [BW-1:0] dac_i = '0;
   logic                 dac_o;

   delta_sigma_dac #(.BW(BW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .dac_i (dac_i),
      .dac_o (dac_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Reference model state as plain integers
   int mx = 0;
   int m1 = 0;
   int m2 = 0;
   int md = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_true(input string name, input bit cond, input int act);
      n_checks++;
      if (!cond) begin
         n_fail++;
         $display("FAIL %s: value %0d out of allowed range at %0t", name, act, $time);
      end
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // One edge of the modulator as defined by the arithmetic rules
   task automatic model_step(input bit rst, input int din);
      int fb, n1, n2;
      if (rst) begin
         mx = 0; m1 = 0; m2 = 0; md = 0;
      end else begin
         fb = (md == 1) ? FS : -FS;
         n1 = clamp(m1 + mx - fb, I1MN, I1MX);
         n2 = clamp(m2 + n1 - fb, I2MN, I2MX);
         mx = din;
         m1 = n1;
         m2 = n2;
         md = (n2 >= 0) ? 1 : 0;
      end
   endtask

   // Per-cycle comparison of DUT against the model, away from the active edge
   always @(negedge clk_i) begin
      int a1, a2;
      if (chk_en) begin
         a1 = dut.int1;
         a2 = dut.int2;
         check("dac_o", int'(dac_o), md);
         check("int1", a1, m1);
         check("int2", a2, m2);
         if (m1 > I1MX || m1 < I1MN || m2 > I2MX || m2 < I2MN) begin
            check_true("model_bounds", 1'b0, m2);
         end
      end
   end

   // Drive one clock with given inputs; returns DUT output seen after the edge
   task automatic cycle(input bit rst, input int din, output bit out);
      rst_i = rst;
      dac_i = din[BW-1:0];
      @(posedge clk_i);
      model_step(rst, din);
      @(negedge clk_i);
      out = dac_o;
   endtask

   // Reset for one edge, then hold din for n edges and count DUT ones
   task automatic run_block(input int din, input int n, output int ones);
      bit o;
      cycle(1'b1, din, o);
      ones = 0;
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, din, o);
         ones += int'(o);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   initial begin
      bit o;
      int ones, prev, expv;
      int golden[7];
      golden = '{1, 1, 0, 1, 0, 0, 1};

      // Reset held three cycles with a non-zero sample
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 5000, o);
         chk_en = 1'b1;
         check("reset_dac_o", int'(o), 0);
      end
      check("reset_int1", int'(dut.int1), 0);
      check("reset_int2", int'(dut.int2), 0);

      // Golden sequence after release with a zero sample
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0, 0, o);
         check($sformatf("golden_%0d", i), int'(o), golden[i]);
      end

      // Mid-scale density
      run_block(0, 4096, ones);
      check_true("mid_scale", iabs(ones - 2048) <= 2, ones);

      // Extremes
      run_block(-8192, 4096, ones);
      check_true("neg_full", ones <= 2, ones);
      run_block(8191, 4096, ones);
      check_true("pos_full", ones >= 4094, ones);

      // Quarter points
      run_block(-4096, 4096, ones);
      check_true("quarter_lo", iabs(ones - 1024) <= 2, ones);
      run_block(4096, 4096, ones);
      check_true("quarter_hi", iabs(ones - 3072) <= 2, ones);

      // Step then mid-stream reset pulse
      cycle(1'b1, 0, o);
      for (int i = 0; i < 500; i++) cycle(1'b0, 2000, o);
      cycle(1'b1, 2000, o);
      check("midrst_dac_o", int'(o), 0);
      check("midrst_int1", int'(dut.int1), 0);
      check("midrst_int2", int'(dut.int2), 0);
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0, 0, o);
         check($sformatf("golden2_%0d", i), int'(o), golden[i]);
      end

      // Monotonicity sweep
      prev = -1;
      for (int v = -8192; v <= 8191; v += 1024) begin
         run_block(v, 2048, ones);
         expv = (v + 8192) / 8;
         check_true($sformatf("sweep_%0d", v), iabs(ones - expv) <= 2, ones);
         check_true($sformatf("mono_%0d", v), ones >= prev, ones);
         prev = ones;
      end

      // Randomized samples, including full scale and occasional resets
      for (int i = 0; i < 3000; i++) begin
         int r;
         case ($urandom_range(0, 9))
            0:       r = -8192;
            1:       r = 8191;
            default: r = int'($urandom_range(0, 16383)) - 8192;
         endcase
         cycle(($urandom_range(0, 199) == 0), r, o);
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
